// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: OV7670 byte stream -> RGB444 {B,G,R} frame-buffer writes plus frame/line bookkeeping.
// Latency: 2 clk from the second byte of a pixel on the pins to pix_we.
// Backpressure: none, because the camera cannot be stalled; writes past the buffer end are dropped and flagged.
// Optional: define CAM_LINE_PAD_EN to drop pixels beyond H_ACTIVE and zero-pad short lines to H_ACTIVE.
module cam_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cam_vsynk,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  input  logic              snap_req,
  input  logic              err_clr,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [11:0]       pix_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [9:0]        line_cnt,
  output logic              err_line,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [15:0]       H_CNT     = 16'(H_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0]  d_q;
  logic        vs_fall, vs_rise, hr_rise, hr_fall;
  logic        cap, arm_go;
  logic        phase;
  logic [3:0]  r_q;
  logic        full_q;
  logic        started_q;
  logic [15:0] px_cnt;
  logic        pix_fire, pad_fire, line_end, line_bad, want_wr, ovf_hit, do_wr;
`ifdef CAM_LINE_PAD_EN
  logic        pad_act;
`endif

  assign vs_fall = vs_qq & ~vs_q;
  assign vs_rise = ~vs_qq & vs_q;
  assign hr_rise = ~hr_qq & hr_q;
  assign hr_fall = hr_qq & ~hr_q;

  // Register camera pins once; the extra vsync/href stage feeds edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_q  <= 1'b0;
      hr_qq <= 1'b0;
      d_q   <= 8'h00;
    end else begin
      vs_q  <= cam_vsynk;
      vs_qq <= vs_q;
      hr_q  <= cam_href;
      hr_qq <= hr_q;
      d_q   <= cam_data;
    end
  end

  // Capture FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: arm on a request, start on vsync fall, end on vsync rise; snap_req only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (snap_req || capture_en) state_nxt = S_ARM;
      S_ARM:     if (vs_fall) state_nxt = S_CAPTURE;
      S_CAPTURE: if (vs_rise) state_nxt = S_DONE;
      S_DONE:    state_nxt = capture_en ? S_ARM : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM decoded outputs
  always_comb begin
    busy   = (state != S_IDLE);
    cap    = (state == S_CAPTURE);
    arm_go = (state == S_ARM) && vs_fall;
  end

  // Write decision: a completed byte pair (or a pad slot) writes unless the buffer is already full
  always_comb begin
    pix_fire = cap && hr_q && phase;
    line_end = cap && hr_fall;
    line_bad = line_end && (px_cnt != H_CNT);
`ifdef CAM_LINE_PAD_EN
    pad_fire = cap && pad_act && !hr_q;
    want_wr  = (pix_fire && (px_cnt < H_CNT)) || pad_fire;
`else
    pad_fire = 1'b0;
    want_wr  = pix_fire;
`endif
    ovf_hit  = want_wr && (full_q || (pix_we && (pix_addr == ADDR_LAST)));
    do_wr    = want_wr && !ovf_hit;
  end

  // Byte pairing: first byte gives R, second byte gives B (low nibble) and G (high nibble)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase    <= 1'b0;
      r_q      <= 4'h0;
      pix_data <= 12'h000;
      pix_we   <= 1'b0;
    end else begin
      phase  <= (cap && hr_q) ? ~phase : 1'b0;
      pix_we <= do_wr;
      if (cap && hr_q && !phase) r_q <= d_q[3:0];
      if (pix_fire)      pix_data <= {d_q[3:0], d_q[7:4], r_q};
      else if (pad_fire) pix_data <= 12'h000;
    end
  end

  // Address: advance after each write, never past the last buffer slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_addr <= '0;
      full_q   <= 1'b0;
    end else if (arm_go) begin
      pix_addr <= '0;
      full_q   <= 1'b0;
    end else if (pix_we) begin
      if (pix_addr == ADDR_LAST) full_q <= 1'b1;
      else                       pix_addr <= pix_addr + 1'b1;
    end
  end

  // Line accounting and frame pulses; pixel count restarts on each href rise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px_cnt      <= 16'h0000;
      line_cnt    <= 10'h000;
      started_q   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= cap && hr_rise && !started_q;
      frame_done  <= cap && vs_rise;
      if (arm_go) begin
        px_cnt    <= 16'h0000;
        line_cnt  <= 10'h000;
        started_q <= 1'b0;
      end else begin
        if (cap && hr_rise) begin
          px_cnt    <= 16'h0000;
          started_q <= 1'b1;
        end else if ((pix_fire || pad_fire) && (px_cnt != 16'hFFFF)) begin
          px_cnt <= px_cnt + 1'b1;
        end
        if (line_end && (line_cnt != 10'h3FF)) line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr stays set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_line <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      if (line_bad)     err_line <= 1'b1;
      else if (err_clr) err_line <= 1'b0;
      if (ovf_hit)      err_ovf  <= 1'b1;
      else if (err_clr) err_ovf  <= 1'b0;
    end
  end

`ifdef CAM_LINE_PAD_EN
  // Zero-pad a short line one pixel per clk; a new href rise abandons the padding
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                      pad_act <= 1'b0;
    else if (!cap || hr_q)                          pad_act <= 1'b0;
    else if (line_end)                              pad_act <= (px_cnt < H_CNT);
    else if (pad_fire && (px_cnt + 16'd1 >= H_CNT)) pad_act <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture on a reduced 4x3 frame: table-driven frames plus reset, latency and snapshot sequences.
module tb_cam_pixel_capture;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cam_vsynk = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          capture_en = 1'b0;
  logic          snap_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [11:0]   pix_data;
  logic          frame_start, frame_done, busy, err_line, err_ovf;
  logic [9:0]    line_cnt;

  cam_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .cam_vsynk(cam_vsynk), .cam_href(cam_href), .cam_data(cam_data),
    .capture_en(capture_en), .snap_req(snap_req), .err_clr(err_clr),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .line_cnt(line_cnt), .err_line(err_line), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0, fs_cnt = 0, fd_cnt = 0, addr_bad = 0, data_bad = 0, first_addr = -1, exp_addr = 0;
  logic fd_prev = 1'b0;
  logic busy_after_fd = 1'b0;

  typedef struct {
    int nl; int short_ln; int odd_ln;
    int exp_wr; int exp_lc; int exp_el; int exp_eo; int exp_addr; int exp_dbad;
  } vec_t;
  vec_t tbl[5];

  // Observe writes and pulses on the falling edge
  always @(negedge clk) begin
    if (fd_prev) busy_after_fd = busy;
    fd_prev = frame_done;
    if (frame_start) fs_cnt++;
    if (frame_done)  fd_cnt++;
    if (pix_we) begin
      if (wr_cnt == 0) first_addr = int'(pix_addr);
      if (int'(pix_addr) != exp_addr) addr_bad++;
      if (pix_data != 12'hC5A) data_bad++;
      exp_addr++;
      wr_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; fs_cnt = 0; fd_cnt = 0; addr_bad = 0; data_bad = 0;
    first_addr = -1; exp_addr = 0; busy_after_fd = 1'b0;
  endtask

  // One href burst; an odd trailing byte is 0xFF so a mispairing corrupts the next pixel
  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      cam_href = 1'b1;
      cam_data = (i == 2*H) ? 8'hFF : ((i % 2 == 0) ? 8'h0A : 8'h5C);
      cyc();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) cyc();
  endtask

  task automatic send_frame(input int nlines, input int short_ln, input int odd_ln, input int snap_ln);
    cam_vsynk = 1'b1; repeat (4) cyc();
    cam_vsynk = 1'b0; repeat (3) cyc();
    for (int l = 0; l < nlines; l++) begin
      if (l == snap_ln) begin snap_req = 1'b1; cyc(); snap_req = 1'b0; end
      send_line((l == short_ln) ? 2*H-2 : ((l == odd_ln) ? 2*H+1 : 2*H));
    end
    cam_vsynk = 1'b1; repeat (4) cyc();
  endtask

  initial begin
    //            nl   short odd  wr   lc  el eo addr dbad
    tbl[0] = '{V,   -1,  -1, H*V,  V,  0, 0, H*V-1, 0};
    tbl[1] = '{V,   -1,  -1, H*V,  V,  0, 0, H*V-1, 0};
`ifdef CAM_LINE_PAD_EN
    tbl[2] = '{V,    1,  -1, H*V,  V,  1, 0, H*V-1, 1};
`else
    tbl[2] = '{V,    1,  -1, H*V-1, V, 1, 0, H*V-1, 0};
`endif
    tbl[3] = '{V,   -1,   1, H*V,  V,  0, 0, H*V-1, 0};
    tbl[4] = '{V+1, -1,  -1, H*V,  V+1, 0, 1, H*V-1, 0};

    #2;
    chk("rst_pix_we", int'(pix_we), 0);
    chk("rst_pix_addr", int'(pix_addr), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({frame_start, frame_done}), 0);
    chk("rst_line_cnt", int'(line_cnt), 0);
    chk("rst_errs", int'({err_line, err_ovf}), 0);
    cyc();
    rstn = 1'b1;
    cyc();

    capture_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clear_mon();
      send_frame(tbl[k].nl, tbl[k].short_ln, tbl[k].odd_ln, -1);
      chk($sformatf("v%0d_writes", k), wr_cnt, tbl[k].exp_wr);
      chk($sformatf("v%0d_frame_start", k), fs_cnt, 1);
      chk($sformatf("v%0d_frame_done", k), fd_cnt, 1);
      chk($sformatf("v%0d_line_cnt", k), int'(line_cnt), tbl[k].exp_lc);
      chk($sformatf("v%0d_err_line", k), int'(err_line), tbl[k].exp_el);
      chk($sformatf("v%0d_err_ovf", k), int'(err_ovf), tbl[k].exp_eo);
      chk($sformatf("v%0d_pix_addr", k), int'(pix_addr), tbl[k].exp_addr);
      chk($sformatf("v%0d_addr_seq", k), addr_bad, 0);
      chk($sformatf("v%0d_data", k), data_bad, tbl[k].exp_dbad);
      chk($sformatf("v%0d_busy_after_done", k), int'(busy_after_fd), 1);
      repeat (2) cyc();
      chk($sformatf("v%0d_err_line_held", k), int'(err_line), tbl[k].exp_el);
      err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
      chk($sformatf("v%0d_err_cleared", k), int'({err_line, err_ovf}), 0);
    end

    // Reset in the middle of a frame, then capture resumes only after the next vsync fall
    clear_mon();
    cam_vsynk = 1'b1; repeat (4) cyc();
    cam_vsynk = 1'b0; repeat (3) cyc();
    send_line(2*H);
    send_line(2*H);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_line_cnt", int'(line_cnt), 2);
    chk("pre_rst_pix_addr", int'(pix_addr), 2*H);
    rstn = 1'b0;
    #1;
    chk("midrst_pix_addr", int'(pix_addr), 0);
    chk("midrst_line_cnt", int'(line_cnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_we_data", int'({pix_we, pix_data}), 0);
    cyc();
    rstn = 1'b1;
    clear_mon();
    send_line(2*H);
    cam_vsynk = 1'b1; repeat (4) cyc();
    chk("no_wr_before_vs_fall", wr_cnt, 0);
    cam_vsynk = 1'b0; repeat (3) cyc();
    cam_href = 1'b1; cam_data = 8'h0A; cyc();
    cam_data = 8'h5C; cyc();
    chk("lat_we_after_1clk", int'(pix_we), 0);
    cyc();
    chk("lat_we_after_2clk", int'(pix_we), 1);
    chk("lat_pix_data", int'(pix_data), 12'hC5A);
    chk("lat_first_addr", int'(pix_addr), 0);
    cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) cyc();
    chk("after_rst_writes", wr_cnt, 1);
    chk("after_rst_first_addr", first_addr, 0);

    // Snapshot: one frame only, a second request while busy is ignored
    rstn = 1'b0; capture_en = 1'b0; cam_vsynk = 1'b0;
    cyc();
    rstn = 1'b1;
    clear_mon();
    cyc();
    snap_req = 1'b1; cyc(); snap_req = 1'b0; cyc();
    chk("snap_busy", int'(busy), 1);
    send_frame(V, -1, -1, 1);
    send_frame(V, -1, -1, -1);
    send_frame(V, -1, -1, -1);
    chk("snap_writes", wr_cnt, H*V);
    chk("snap_frame_start", fs_cnt, 1);
    chk("snap_frame_done", fd_cnt, 1);
    chk("snap_busy_after_done", int'(busy_after_fd), 0);
    chk("snap_idle_busy", int'(busy), 0);
    chk("snap_addr_seq", addr_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
